// File: rtl/pc_sequencer.sv
// Multicycle FETCH/EXEC/WRBACK/TRAP sequencer for the OTTER PC datapath, with bus-timeout and interrupt traps.
// Build option INTR_LATCH_EN: latch 1-cycle intr pulses until the next trap is taken.
module pc_sequencer #(
  parameter int TIMEOUT_CYC = 15,
  parameter int PC_SEL_W    = 3
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                mem_ready,
  input  logic                is_load,
  input  logic                is_jal,
  input  logic                is_jalr,
  input  logic                is_branch,
  input  logic                br_taken,
  input  logic                is_mret,
  input  logic                rf_wr_req,
  input  logic                csr_wr_req,
  input  logic                intr,
  input  logic                mie,
  output logic                pc_rst,
  output logic                PC_WE,
  output logic [PC_SEL_W-1:0] PC_SEL,
  output logic                ir_we,
  output logic                mem_rden1,
  output logic                mem_rden2,
  output logic                rf_we,
  output logic                csr_we,
  output logic                int_taken,
  output logic [1:0]          trap_cause,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {FETCH, EXEC, WRBACK, TRAP} state_t;

  localparam int TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TLAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [TW-1:0] TLAST_V = TLAST[TW-1:0];
  localparam logic [PC_SEL_W-1:0] SEL_PC4   = PC_SEL_W'(0);
  localparam logic [PC_SEL_W-1:0] SEL_JALR  = PC_SEL_W'(1);
  localparam logic [PC_SEL_W-1:0] SEL_BR    = PC_SEL_W'(2);
  localparam logic [PC_SEL_W-1:0] SEL_JAL   = PC_SEL_W'(3);
  localparam logic [PC_SEL_W-1:0] SEL_MTVEC = PC_SEL_W'(4);
  localparam logic [PC_SEL_W-1:0] SEL_MEPC  = PC_SEL_W'(5);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cause_q, cause_d;
  logic          irq_req;
  logic          timeout_hit;

`ifdef INTR_LATCH_EN
  logic pend_q, pend_d;
  assign irq_req = pend_q | intr;
`else
  assign irq_req = intr;
`endif

  assign pc_rst    = RST;
  assign state_dbg = state_q;
  // mem_ready on the last allowed cycle wins over the timeout
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TLAST_V) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    timer_d    = '0;
    PC_WE      = 1'b0;
    PC_SEL     = SEL_PC4;
    ir_we      = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    trap_cause = 2'd0;
    case (state_q)
      FETCH: begin
        mem_rden1 = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = EXEC;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = 2'd1;
        end
      end
      EXEC: begin
        if (is_load) begin
          mem_rden2 = 1'b1;
          state_d   = WRBACK;
        end else begin
          PC_WE  = 1'b1;
          rf_we  = rf_wr_req;
          csr_we = csr_wr_req;
          if (is_mret)                     PC_SEL = SEL_MEPC;
          else if (is_jal)                 PC_SEL = SEL_JAL;
          else if (is_jalr)                PC_SEL = SEL_JALR;
          else if (is_branch && br_taken)  PC_SEL = SEL_BR;
          if (irq_req && mie) begin
            state_d = TRAP;
            cause_d = 2'd0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRBACK: begin
        mem_rden2 = 1'b1;
        if (mem_ready) begin
          rf_we = 1'b1;
          PC_WE = 1'b1;
          if (irq_req && mie) begin
            state_d = TRAP;
            cause_d = 2'd0;
          end else begin
            state_d = FETCH;
          end
        end else if (timeout_hit) begin
          // PC is left on the faulting load so mepc points at it
          state_d = TRAP;
          cause_d = 2'd2;
        end
      end
      TRAP: begin
        PC_WE      = 1'b1;
        PC_SEL     = SEL_MTVEC;
        int_taken  = 1'b1;
        trap_cause = cause_q;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if ((state_q == FETCH || state_q == WRBACK) && state_d == state_q)
      timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
`ifdef INTR_LATCH_EN
    pend_d = pend_q;
    if (int_taken)  pend_d = 1'b0;
    else if (intr)  pend_d = 1'b1;
`endif
    if (RST) begin
      PC_WE      = 1'b0;
      PC_SEL     = SEL_PC4;
      ir_we      = 1'b0;
      mem_rden1  = 1'b0;
      mem_rden2  = 1'b0;
      rf_we      = 1'b0;
      csr_we     = 1'b0;
      int_taken  = 1'b0;
      trap_cause = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= FETCH;
      timer_q <= '0;
      cause_q <= 2'd0;
`ifdef INTR_LATCH_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cause_q <= cause_d;
`ifdef INTR_LATCH_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule
